// File: rtl/axis_cic_pkg.sv
// ============================================================================
// Module : axis_cic_pkg
// Brief  : Shared CIC definitions (width function, bit mapping, sample type).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_cic_pkg;

  // Register growth is N*log2(R*M) with M=1, plus 2 bits for the +/-1 input.
  function automatic int cic_iw(input int r, input int n);
    return 2 + n * $clog2(r);
  endfunction

  typedef logic signed [1:0] cic_bit_sample_t;

  localparam cic_bit_sample_t c_cic_bit_one  = 2'sb01;
  localparam cic_bit_sample_t c_cic_bit_zero = 2'sb11;

endpackage

`default_nettype wire

// File: rtl/cic_decim_comb_stage.sv
// ============================================================================
// Module : cic_decim_comb_stage
// Brief  : One CIC comb section, y = x - x_prev, advancing only when enabled.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_decim_comb_stage #(
  parameter int IW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic signed [IW-1:0] i_x,
  output logic signed [IW-1:0] o_y
);

  logic signed [IW-1:0] dly_d, dly_q;
  logic signed [IW-1:0] y_d, y_q;

  // The difference is registered so each stage adds one pipeline step.
  always_comb begin
    dly_d = dly_q;
    y_d   = y_q;
    if (i_en) begin
      dly_d = i_x;
      y_d   = i_x - dly_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
      y_q   <= '0;
    end else begin
      dly_q <= dly_d;
      y_q   <= y_d;
    end
  end

  assign o_y = y_q;

endmodule

`default_nettype wire

// File: rtl/axis_cic_decimator.sv
// ============================================================================
// Module : axis_cic_decimator
// Brief  : AXI-Stream CIC decimator for a 1-bit DSM stream.
//          AXIS_CIC_DECIMATOR_ROUND_EN selects round-half-up with saturation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_cic_decimator
  import axis_cic_pkg::*;
#(
  parameter int R         = 100,
  parameter int N         = 2,
  parameter int OUT_WIDTH = 12
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready
);

  localparam int IW    = cic_iw(R, N);
  localparam int SHIFT = IW - OUT_WIDTH;
  localparam int PW    = $clog2(R);
  localparam logic [PW-1:0] c_phase_last = PW'(R - 1);

  logic                 rdy_q;
  logic [PW-1:0]        phase_d, phase_q;
  logic [N:0]           stb_d, stb_q;
  logic signed [IW-1:0] integ_d [N];
  logic signed [IW-1:0] integ_q [N];
  logic [OUT_WIDTH-1:0] tdata_d, tdata_q;
  logic                 tvalid_d, tvalid_q;

  logic                 w_accept;
  logic                 w_strobe;
  cic_bit_sample_t      w_in_bit;
  logic signed [IW-1:0] w_in_ext;
  logic signed [IW-1:0] comb_x [N+1];
  logic [OUT_WIDTH-1:0] w_reduced;

  assign s_axis_data_tready = rdy_q & ~(tvalid_q & ~m_axis_data_tready);
  assign w_accept = s_axis_data_tvalid & s_axis_data_tready;
  assign w_strobe = w_accept && (phase_q == c_phase_last);
  assign w_in_bit = s_axis_data_tdata ? c_cic_bit_one : c_cic_bit_zero;
  assign w_in_ext = {{(IW-2){w_in_bit[1]}}, w_in_bit};

  always_comb begin
    phase_d = phase_q;
    integ_d = integ_q;
    if (w_accept) begin
      phase_d    = w_strobe ? '0 : phase_q + 1'b1;
      integ_d[0] = integ_q[0] + w_in_ext;
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  // stb_q[k] enables comb stage k; stb_q[N] loads the output register.
  assign stb_d = {stb_q[N-1:0], w_strobe};

  assign comb_x[0] = integ_q[N-1];

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_decim_comb_stage #(
      .IW (IW)
    ) u_comb (
      .clk  (aclk),
      .rst  (arst),
      .i_en (stb_q[g]),
      .i_x  (comb_x[g]),
      .o_y  (comb_x[g+1])
    );
  end

`ifdef AXIS_CIC_DECIMATOR_ROUND_EN
  localparam logic signed [IW:0] c_half = (IW+1)'((1 << SHIFT) >> 1);
  localparam logic [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IW:0]        w_rnd_sum;
  logic signed [OUT_WIDTH:0] w_rnd_shift;
  logic [IW:0]               w_unused_bits;

  assign w_rnd_sum     = {comb_x[N][IW-1], comb_x[N]} + c_half;
  assign w_rnd_shift   = w_rnd_sum[IW:SHIFT];
  assign w_unused_bits = w_rnd_sum;

  // One guard bit above the output range detects overflow from the +half.
  always_comb begin
    w_reduced = w_rnd_shift[OUT_WIDTH-1:0];
    if (w_rnd_shift[OUT_WIDTH] != w_rnd_shift[OUT_WIDTH-1]) begin
      w_reduced = w_rnd_shift[OUT_WIDTH] ? c_out_min : c_out_max;
    end
  end
`else
  logic [IW-1:0] w_unused_bits;

  assign w_reduced     = comb_x[N][IW-1:SHIFT];
  assign w_unused_bits = comb_x[N];
`endif

  // A sample completing on the handshake edge replaces the one leaving.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (tvalid_q && m_axis_data_tready) begin
      tvalid_d = 1'b0;
    end
    if (stb_q[N]) begin
      tvalid_d = 1'b1;
      tdata_d  = w_reduced;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rdy_q    <= 1'b0;
      phase_q  <= '0;
      stb_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
      end
    end else begin
      rdy_q    <= 1'b1;
      phase_q  <= phase_d;
      stb_q    <= stb_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
      end
    end
  end

  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule

`default_nettype wire

// File: doc/axis_cic_decimator.md
AXIS_CIC_DECIMATOR -- requirements
Module: axis_cic_decimator

Interface
- REQ-001: Parameter R, default 100, decimation ratio; legal range is R >= N+2.
- REQ-002: Parameter N, default 2, number of integrator/comb stages; legal range is 1..4.
- REQ-003: Parameter OUT_WIDTH, default 12, output sample width; legal range is OUT_WIDTH <= IW.
- REQ-004: aclk  in  1  single clock; all state changes on its rising edge.
- REQ-005: arst  in  1  reset, asynchronous, active-high.
- REQ-006: s_axis_data_tdata  in  1  DSM bitstream bit.
- REQ-007: s_axis_data_tvalid  in  1  input beat valid.
- REQ-008: s_axis_data_tready  out  1  input beat accepted when high with tvalid.
- REQ-009: m_axis_data_tdata  out  OUT_WIDTH  signed decimated sample.
- REQ-010: m_axis_data_tvalid  out  1  output sample valid.
- REQ-011: m_axis_data_tready  in  1  downstream accepts the output sample.

Function
- REQ-012: Input mapping: bit 1 -> +1 and bit 0 -> -1, as a 2-bit two's complement value.
- REQ-013: Internal width IW = 2 + N*$clog2(R); all integrator and comb arithmetic is IW-bit two's complement, wrapping modulo 2^IW.
- REQ-014: On each accepted beat, integrator stage k adds the output of stage k-1 (stage 1 adds the mapped input). Integrators are registered and update only on accepted beats.
- REQ-015: Phase counter: runs 0..R-1, increments per accepted beat, and wraps to 0 on the beat accepted at R-1. That beat raises a one-cycle decimation strobe.
- REQ-016: Decimation and combs:
  - The strobe samples the last integrator into the comb chain.
  - Each comb stage computes y = x - x_prev (differential delay M=1), with one register per stage, advancing only on strobe-pipeline cycles.
- REQ-017: Latency: m_axis_data_tvalid rises on the (N+1)th rising edge after the edge that accepts the R-th beat.
- REQ-018: Output reduction: the comb result is reduced to OUT_WIDTH by arithmetic right shift of IW-OUT_WIDTH bits, unless ROUND is enabled (REQ-026).
- REQ-019: m_axis_data_tvalid and m_axis_data_tdata are held stable until the cycle with m_axis_data_tvalid && m_axis_data_tready. m_axis_data_tvalid clears on that edge unless a new sample completes on the same edge, in which case tvalid stays high with the new data.
- REQ-020: Backpressure: s_axis_data_tready = 0 while m_axis_data_tvalid && !m_axis_data_tready; otherwise 1 (outside reset). No sample is ever dropped.
- REQ-021: A stalled input (tvalid=0 or tready=0) freezes the integrators and the phase counter; the comb pipeline still drains.

Reset
- REQ-022: While arst is high, the following are 0:
  - all integrators, comb delay registers and the phase counter;
  - m_axis_data_tdata, m_axis_data_tvalid and s_axis_data_tready.
- REQ-023: Reset asserted mid-frame discards any partial frame and any pending output. The first output after release requires R fresh accepted beats.
- REQ-024: s_axis_data_tready goes to 1 on the first rising edge after arst deasserts.

Configuration
- REQ-025: Macro AXIS_CIC_DECIMATOR_ROUND_EN selects the output rounding mode.
- REQ-026: AXIS_CIC_DECIMATOR_ROUND_EN defined: round half-up before the shift by adding 2^(IW-OUT_WIDTH-1), then saturate to the OUT_WIDTH signed range.
- REQ-027: AXIS_CIC_DECIMATOR_ROUND_EN undefined: plain truncation with no saturation logic present. Latency is identical in both modes.

Structure
- REQ-028: Package axis_cic_pkg holds the IW width function, the input-mapping constants and the sample typedef; it is shared with the interpolating chain.
- REQ-029: The comb stage is a sub-module, cic_decim_comb_stage (one register, enable, IW parameter), instantiated N times via generate. The integrators are inline.

Verification
- REQ-030: Scenario, all-ones, defaults (R=100, N=2): R*4 all-ones beats -> from the 3rd output onward tdata = 625 (10000>>4), one output per 100 beats.
- REQ-031: Scenario, all-zeros: same as REQ-030 with all-zeros input -> steady tdata = -625.
- REQ-032: Scenario, alternating 1,0: alternating input -> steady tdata = 0. Latency check: tvalid rises exactly 3 edges after the edge accepting beat 100.
- REQ-033: Scenario, backpressure: m_axis_data_tready held 0 for 300 cycles -> s_axis_data_tready drops after the first output, tdata stays stable, and no output is lost or duplicated after release.
- REQ-034: Scenario, reset mid-frame: arst pulsed at beat 57 -> all outputs read 0, and the next tvalid occurs only after 100 new beats.
- REQ-035: Scenario, ROUND enabled: with AXIS_CIC_DECIMATOR_ROUND_EN defined and 75% ones density -> steady output equals round(5000/16) = 313, versus 312 truncated.
